// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
// The receive word carries a 2-bit command code above the payload.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA,
        ST_WAIT_TX,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic int rx_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// SPI pins, RAM-side receive/transmit signals and FSM debug taps for spi_slave_param.
// tx_valid is a level qualifier with no ready: it is only looked at in WAIT_TX, and the word is taken on that edge.
interface spi_slave_param_if
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) ();
    localparam int RX_W = rx_w(DATA_W);

    logic              SS_n;
    logic              MOSI;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              MISO;
    logic [RX_W-1:0]   rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;
    state_e            dbg_state;
    logic              dbg_rd_addr_seen;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, frame_err, busy, dbg_state, dbg_rd_addr_seen
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, frame_err, busy, dbg_state, dbg_rd_addr_seen
    );

endinterface

// File: rtl/spi_shift_reg.sv
// Shift register with parallel load, shifting in the configured bit order.
// The serial output is always the bit that leaves first.
module spi_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic             sout_o,
    output logic [WIDTH-1:0] pout_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = pin_i;
        end else if (shift_en_i) begin
            data_d = MSB_FIRST ? {data_q[WIDTH-2:0], sin_i} : {sin_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sout_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];
    assign pout_o = data_q;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises command+payload frames from MOSI and
// serialises RAM read data on MISO after a tx_valid handshake.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit MISO_IDLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_param_if.slave bus
);
    localparam int RX_W  = rx_w(DATA_W);
    localparam int CNT_W = $clog2(RX_W + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rd_addr_seen_q;
    logic               miso_q;
    logic               rx_valid_q;
    logic               frame_err_q;
    logic               busy_q;

    logic               abort;
    logic               in_shift;
    logic               rx_load;
    logic               rx_shift;
    logic               tx_load;
    logic               tx_shift;
    logic               tx_head;
    logic [DATA_W-1:0]  tx_pin;
    logic               tx_sout;
    logic [RX_W-1:0]    rx_word;
    logic               rx_sout_unused;
    logic [DATA_W-1:0]  tx_pout_unused;

    // Any SS_n rise outside IDLE/DONE kills the frame, and wins over a last bit on the same edge.
    always_comb begin
        in_shift = (state_q == ST_WRITE) || (state_q == ST_READ_ADD) || (state_q == ST_READ_DATA);
        abort    = bus.SS_n && (state_q != ST_IDLE) && (state_q != ST_DONE);
        rx_load  = abort || (state_q == ST_CHK_CMD);
        rx_shift = in_shift && !bus.SS_n;
        tx_load  = abort || ((state_q == ST_WAIT_TX) && bus.tx_valid);
        tx_shift = (state_q == ST_SEND) && !bus.SS_n;
        tx_head  = MSB_FIRST ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
        tx_pin   = '0;
        if (!abort) begin
            // The head bit goes straight to MISO, so the register holds the rest.
            tx_pin = MSB_FIRST ? {bus.tx_data[DATA_W-2:0], 1'b0} : {1'b0, bus.tx_data[DATA_W-1:1]};
        end
    end

    spi_shift_reg #(.WIDTH(RX_W), .MSB_FIRST(MSB_FIRST)) u_rx_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (rx_load),
        .shift_en_i (rx_shift),
        .sin_i      (bus.MOSI),
        .pin_i      ('0),
        .sout_o     (rx_sout_unused),
        .pout_o     (rx_word)
    );

    spi_shift_reg #(.WIDTH(DATA_W), .MSB_FIRST(MSB_FIRST)) u_tx_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tx_load),
        .shift_en_i (tx_shift),
        .sin_i      (1'b0),
        .pin_i      (tx_pin),
        .sout_o     (tx_sout),
        .pout_o     (tx_pout_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rd_addr_seen_q <= 1'b0;
            miso_q         <= MISO_IDLE;
            rx_valid_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (abort) begin
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                cnt_q       <= '0;
                miso_q      <= MISO_IDLE;
                frame_err_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!bus.SS_n) begin
                            state_q <= ST_CHK_CMD;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    ST_CHK_CMD: begin
                        cnt_q <= '0;
                        if (!bus.MOSI)           state_q <= ST_WRITE;
                        else if (!rd_addr_seen_q) state_q <= ST_READ_ADD;
                        else                     state_q <= ST_READ_DATA;
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        if (cnt_q == CNT_W'(RX_W - 1)) begin
                            cnt_q      <= '0;
                            rx_valid_q <= 1'b1;
                            if (state_q == ST_READ_DATA) begin
                                state_q <= ST_WAIT_TX;
                            end else begin
                                state_q <= ST_DONE;
                                if (state_q == ST_READ_ADD) rd_addr_seen_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_WAIT_TX: begin
                        if (bus.tx_valid) begin
                            miso_q  <= tx_head;
                            cnt_q   <= '0;
                            state_q <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            miso_q         <= MISO_IDLE;
                            rd_addr_seen_q <= 1'b0;
                            cnt_q          <= '0;
                            state_q        <= ST_DONE;
                        end else begin
                            miso_q <= tx_sout;
                            cnt_q  <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (bus.SS_n) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.MISO             = miso_q;
    assign bus.rx_data          = rx_word;
    assign bus.rx_valid         = rx_valid_q;
    assign bus.frame_err        = frame_err_q;
    assign bus.busy             = busy_q;
    assign bus.dbg_state        = state_q;
    assign bus.dbg_rd_addr_seen = rd_addr_seen_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: 8-bit MSB-first instance for frame/abort/read/reset
// sequences and a 16-bit LSB-first instance for the wide path.
module tb_spi_slave_param;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8))  bus_a ();
    spi_slave_param_if #(.DATA_W(16)) bus_b ();

    spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1), .MISO_IDLE(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0), .MISO_IDLE(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;
    int ferr_a = 0;
    logic [9:0]  exp_a_q[$];
    logic [17:0] exp_b_q[$];
    logic        miso_q[$];

    typedef struct {
        bit         cmd;
        logic [9:0] bits;
        logic [9:0] exp_rx;
        state_e     exp_st;
        bit         exp_seen;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every rx_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus_a.rx_valid) begin
            if (exp_a_q.size() == 0) check("a_rx_spurious", bus_a.rx_valid, 1'b0);
            else                     check("a_rx_data", bus_a.rx_data, exp_a_q.pop_front());
        end
        if (rst_n && bus_a.frame_err) ferr_a++;
        if (rst_n && bus_b.rx_valid) begin
            if (exp_b_q.size() == 0) check("b_rx_spurious", bus_b.rx_valid, 1'b0);
            else                     check("b_rx_data", bus_b.rx_data, exp_b_q.pop_front());
        end
    end

    task automatic frame_a(input bit cmd, input logic [9:0] word, input logic [9:0] exp_rx,
                           input state_e exp_st, input int abort_at);
        @(negedge clk);
        bus_a.SS_n = 1'b0;
        @(negedge clk);
        check("a_chk_state", bus_a.dbg_state, ST_CHK_CMD);
        check("a_busy_hi", bus_a.busy, 1'b1);
        bus_a.MOSI = cmd;
        @(negedge clk);
        check("a_shift_state", bus_a.dbg_state, exp_st);
        check("a_rx_cleared", bus_a.rx_data, 10'h000);
        if (abort_at < 0) exp_a_q.push_back(exp_rx);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            bus_a.MOSI = word[9-i];
            if (i == abort_at) begin
                bus_a.SS_n = 1'b1;
                break;
            end
        end
        if (abort_at >= 0) begin
            @(negedge clk);
            check("a_abort_ferr", bus_a.frame_err, 1'b1);
            check("a_abort_novalid", bus_a.rx_valid, 1'b0);
            check("a_abort_idle", bus_a.dbg_state, ST_IDLE);
            check("a_abort_busy", bus_a.busy, 1'b0);
            @(negedge clk);
            check("a_ferr_pulse", bus_a.frame_err, 1'b0);
        end else begin
            check("a_valid_early", bus_a.rx_valid, 1'b0);
            @(negedge clk);
            check("a_valid_edge", bus_a.rx_valid, 1'b1);
            check("a_no_ferr", bus_a.frame_err, 1'b0);
        end
    endtask

    task automatic close_a(input logic [9:0] hold);
        @(negedge clk);
        check("a_done_state", bus_a.dbg_state, ST_DONE);
        check("a_valid_pulse", bus_a.rx_valid, 1'b0);
        check("a_busy_done", bus_a.busy, 1'b1);
        check("a_rx_hold", bus_a.rx_data, hold);
        bus_a.SS_n = 1'b1;
        @(negedge clk);
        check("a_idle_state", bus_a.dbg_state, ST_IDLE);
        check("a_busy_fall", bus_a.busy, 1'b0);
    endtask

    task automatic tx_a(input logic [7:0] data, input int wait_cycles);
        repeat (wait_cycles) begin
            @(negedge clk);
            check("a_wait_state", bus_a.dbg_state, ST_WAIT_TX);
            check("a_miso_idle_wait", bus_a.MISO, 1'b0);
        end
        bus_a.tx_data  = data;
        bus_a.tx_valid = 1'b1;
        for (int k = 0; k < 8; k++) miso_q.push_back(data[7-k]);
        miso_q.push_back(1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus_a.tx_valid = 1'b0;
                bus_a.tx_data  = 8'h00;
            end
            check("a_miso_bit", bus_a.MISO, miso_q.pop_front());
        end
        check("a_send_done", bus_a.dbg_state, ST_DONE);
        check("a_seen_cleared", bus_a.dbg_rd_addr_seen, 1'b0);
    endtask

    task automatic frame_b(input bit cmd, input logic [17:0] word, input logic [17:0] exp_rx,
                           input state_e exp_st);
        @(negedge clk);
        bus_b.SS_n = 1'b0;
        @(negedge clk);
        bus_b.MOSI = cmd;
        @(negedge clk);
        check("b_shift_state", bus_b.dbg_state, exp_st);
        exp_b_q.push_back(exp_rx);
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            bus_b.MOSI = word[i];
        end
        check("b_valid_early", bus_b.rx_valid, 1'b0);
        @(negedge clk);
        check("b_valid_edge", bus_b.rx_valid, 1'b1);
    endtask

    task automatic close_b(input state_e exp_st);
        @(negedge clk);
        check("b_done_state", bus_b.dbg_state, exp_st);
        bus_b.SS_n = 1'b1;
        @(negedge clk);
        check("b_idle_state", bus_b.dbg_state, ST_IDLE);
        check("b_busy_fall", bus_b.busy, 1'b0);
    endtask

    task automatic tx_b(input logic [15:0] data, input int wait_cycles);
        repeat (wait_cycles) begin
            @(negedge clk);
            check("b_wait_state", bus_b.dbg_state, ST_WAIT_TX);
        end
        bus_b.tx_data  = data;
        bus_b.tx_valid = 1'b1;
        for (int k = 0; k < 16; k++) miso_q.push_back(data[k]);
        miso_q.push_back(1'b0);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus_b.tx_valid = 1'b0;
                bus_b.tx_data  = 16'h0000;
            end
            check("b_miso_bit", bus_b.MISO, miso_q.pop_front());
        end
    endtask

    task automatic check_reset_a();
        check("rst_miso", bus_a.MISO, 1'b0);
        check("rst_rx_data", bus_a.rx_data, 10'h000);
        check("rst_rx_valid", bus_a.rx_valid, 1'b0);
        check("rst_frame_err", bus_a.frame_err, 1'b0);
        check("rst_busy", bus_a.busy, 1'b0);
        check("rst_state", bus_a.dbg_state, ST_IDLE);
        check("rst_seen", bus_a.dbg_rd_addr_seen, 1'b0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog run did not complete by %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [9:0] word;
        int         f0;

        vecs[0] = '{cmd: 1'b0, bits: 10'b00_1010_0101, exp_rx: 10'h0A5, exp_st: ST_WRITE,    exp_seen: 1'b0};
        vecs[1] = '{cmd: 1'b0, bits: 10'b01_0011_1100, exp_rx: 10'h13C, exp_st: ST_WRITE,    exp_seen: 1'b0};
        vecs[2] = '{cmd: 1'b1, bits: 10'b10_0000_0011, exp_rx: 10'h203, exp_st: ST_READ_ADD, exp_seen: 1'b1};

        bus_a.SS_n = 1'b1; bus_a.MOSI = 1'b0; bus_a.tx_valid = 1'b0; bus_a.tx_data = '0;
        bus_b.SS_n = 1'b1; bus_b.MOSI = 1'b0; bus_b.tx_valid = 1'b0; bus_b.tx_data = '0;
        repeat (3) @(negedge clk);
        check_reset_a();
        check("rst_b_rx_data", bus_b.rx_data, 18'h0);
        check("rst_b_busy", bus_b.busy, 1'b0);
        rst_n = 1'b1;

        // Table: write address, write data, then a read command straight after reset takes READ_ADD.
        for (int v = 0; v < 3; v++) begin
            frame_a(vecs[v].cmd, vecs[v].bits, vecs[v].exp_rx, vecs[v].exp_st, -1);
            close_a(vecs[v].exp_rx);
            check("a_seen_after", bus_a.dbg_rd_addr_seen, vecs[v].exp_seen);
        end

        // Read data: goes through WAIT_TX, tx_valid three cycles later, 0xC3 out MSB first.
        frame_a(1'b1, 10'b11_0000_0000, 10'h300, ST_READ_DATA, -1);
        tx_a(8'hC3, 3);
        close_a(10'h300);

        // With the address flag cleared by the send, a read command is an address again.
        frame_a(1'b1, {CMD_RD_ADDR, 8'h7E}, 10'h27E, ST_READ_ADD, -1);
        close_a(10'h27E);

        // Abort after 5 payload bits, then on the same edge as the last bit.
        f0 = ferr_a;
        frame_a(1'b0, 10'h155, 10'h155, ST_WRITE, 5);
        check("a_ferr_count_mid", ferr_a - f0, 1);
        frame_a(1'b0, {CMD_WR_DATA, 8'h66}, 10'h166, ST_WRITE, -1);
        close_a(10'h166);
        f0 = ferr_a;
        frame_a(1'b0, 10'h0F0, 10'h0F0, ST_WRITE, 9);
        check("a_ferr_count_last", ferr_a - f0, 1);
        check("a_seen_kept", bus_a.dbg_rd_addr_seen, 1'b1);

        for (int r = 0; r < 4; r++) begin
            word = {((r % 2) == 0) ? CMD_WR_ADDR : CMD_WR_DATA, 8'($urandom_range(0, 255))};
            frame_a(1'b0, word, word, ST_WRITE, -1);
            close_a(word);
        end

        // Wide LSB-first instance: write, address, then a 16-bit read.
        frame_b(1'b0, 18'h1BEEF, 18'h1BEEF, ST_WRITE);
        close_b(ST_DONE);
        frame_b(1'b1, 18'h20010, 18'h20010, ST_READ_ADD);
        close_b(ST_DONE);
        frame_b(1'b1, 18'h30000, 18'h30000, ST_READ_DATA);
        tx_b(16'h8001, 3);
        check("b_seen_cleared", bus_b.dbg_rd_addr_seen, 1'b0);
        close_b(ST_DONE);

        // Reset in the middle of a send.
        frame_a(1'b1, 10'h3A5, 10'h3A5, ST_READ_DATA, -1);
        @(negedge clk);
        bus_a.tx_data  = 8'h5A;
        bus_a.tx_valid = 1'b1;
        miso_q.push_back(1'b0); miso_q.push_back(1'b1); miso_q.push_back(1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) bus_a.tx_valid = 1'b0;
            check("a_miso_pre_rst", bus_a.MISO, miso_q.pop_front());
        end
        rst_n      = 1'b0;
        bus_a.SS_n = 1'b1;
        @(negedge clk);
        check_reset_a();
        rst_n = 1'b1;
        frame_a(1'b1, 10'h2C3, 10'h2C3, ST_READ_ADD, -1);
        close_a(10'h2C3);

        repeat (2) @(negedge clk);
        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
